// File: rtl/seq_mult_n.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_n
//  Description : Parametrised sequential shift-add multiplier. Takes two
//                WIDTH-bit operands (unsigned or two's-complement, chosen per
//                request) and returns a 2*WIDTH-bit product WIDTH cycles after
//                the request is accepted. Start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand width in bits (2..32); product is 2*WIDTH bits
//  Ports
//    clk        in   1        rising-edge clock
//    rst        in   1        synchronous active-high reset
//    start      in   1        request, sampled only while idle
//    is_signed  in   1        1: operands are two's-complement, 0: unsigned
//    a          in   WIDTH    multiplicand, sampled with start
//    b          in   WIDTH    multiplier, sampled with start
//    busy       out  1        operation in progress
//    done       out  1        one-cycle pulse, p valid in this cycle
//    p          out  2*WIDTH  product, held until next completion or reset
// ============================================================================
module seq_mult_n #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    // Counter must be able to hold WIDTH after the final step.
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_CNT_1  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [WIDTH-1:0]       r_mcand;     // |a|
    logic [WIDTH-1:0]       r_acc;       // upper half of the running product
    logic [WIDTH-1:0]       r_mplier;    // |b|, shifted out as product bits shift in
    logic                   r_neg;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_p;

    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_neg;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_acc_nxt;
    logic [WIDTH-1:0]       w_mplier_nxt;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_result;
    logic                   w_last;

    // Magnitudes: negating the most negative value wraps back to itself,
    // which read as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    assign w_a_mag = (is_signed && a[WIDTH-1]) ? (-a) : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? (-b) : b;

    // A zero operand forces a positive result so -0 never has to be handled.
    assign w_neg   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (|a) & (|b);

    // One shift-add step: conditional add into the upper half keeping the
    // carry, then shift {carry, acc, mplier} right by one.
    assign w_addend     = r_mplier[0] ? r_mcand : '0;
    assign w_sum        = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_acc_nxt    = w_sum[WIDTH:1];
    assign w_mplier_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
    assign w_prod       = {w_acc_nxt, w_mplier_nxt};
    assign w_result     = r_neg ? (-w_prod) : w_prod;

    assign w_last = (r_state == S_RUN) && (r_cnt == C_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_p      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_neg    <= w_neg;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + C_CNT_1;
                    if (r_cnt == C_LAST) begin
                        r_p    <= w_result;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign p    = r_p;

endmodule
`default_nettype wire
